// File: rtl/issue_select_unit_pkg.sv
// Shared types for the issue stage.
//   RS_ENTRY      : one reservation-station entry as seen by the issue stage
//   ROB_IDX       : ROB index type (ROB of 32 entries)
//   ISSUE_POLICY  : selection rank, oldest-by-ROB-age or lowest RS index
//   rs_ready()    : entry is valid with both sources available
//   idx_width()   : index width for an array of n entries (minimum 1 bit)
package issue_select_unit_pkg;

  localparam int unsigned ROB_SZ_DEF = 32;
  localparam int unsigned ROB_IDX_W  = $clog2(ROB_SZ_DEF);

  typedef logic [ROB_IDX_W-1:0] ROB_IDX;

  typedef struct packed {
    logic       valid;
    logic       src1_ready;
    logic       src2_ready;
    ROB_IDX     rob_idx;
    logic [3:0] opcode;
    logic [4:0] dest_tag;
  } RS_ENTRY;

  typedef enum logic {
    OLDEST = 1'b0,
    INDEX  = 1'b1
  } ISSUE_POLICY;

  function automatic logic rs_ready(input RS_ENTRY e);
    return e.valid & e.src1_ready & e.src2_ready;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/issue_select_unit_oldest_picker.sv
// Combinational single-winner picker.
//   req       : candidate mask
//   age       : per-candidate age, smaller is older
//   grant     : one-hot winner (all zero when no candidate)
//   grant_idx : binary index of the winner (0 when none)
//   found     : a winner exists
// Equal ages resolve to the lower index because only a strictly smaller
// age displaces the current best while scanning upwards.
module oldest_picker #(
  parameter int unsigned RS_SZ = 8,
  parameter int unsigned AGE_W = 5,
  parameter int unsigned IDX_W = 3
) (
  input  logic [RS_SZ-1:0]            req,
  input  logic [RS_SZ-1:0][AGE_W-1:0] age,
  output logic [RS_SZ-1:0]            grant,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        found
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    best_age  = '0;
    for (int unsigned i = 0; i < RS_SZ; i++) begin
      if (req[i] && (!found || (age[i] < best_age))) begin
        found     = 1'b1;
        best_age  = age[i];
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_select_unit.sv
// Per-category issue stage: selects up to NUM_FU ready RS entries per cycle
// and latches them into per-FU issue registers.
//   clock, reset  : clock and synchronous active-high reset
//   mispredict    : flush, same effect as reset on this block
//   rs_entries    : contents of the attached RS bank
//   rob_head      : index of the oldest in-flight instruction
//   fu_ready      : FU f accepts issue_entry[f] this cycle
//   issue_valid   : issue register f holds a live entry
//   issue_entry   : contents of issue register f
//   clear_valid   : RS drops clear_idx[f] at this posedge
//   clear_idx     : RS index being selected for slot f
module issue_select_unit
  import issue_select_unit_pkg::*;
#(
  parameter int unsigned RS_SZ    = 8,
  parameter int unsigned NUM_FU   = 2,
  parameter int unsigned ROB_SZ   = 32,
  parameter ISSUE_POLICY POLICY   = OLDEST,
  localparam int unsigned AGE_W    = $clog2(ROB_SZ),
  localparam int unsigned RS_IDX_W = idx_width(RS_SZ)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              mispredict,
  input  RS_ENTRY [RS_SZ-1:0]               rs_entries,
  input  logic [AGE_W-1:0]                  rob_head,
  input  logic [NUM_FU-1:0]                 fu_ready,
  output logic [NUM_FU-1:0]                 issue_valid,
  output RS_ENTRY [NUM_FU-1:0]              issue_entry,
  output logic [NUM_FU-1:0]                 clear_valid,
  output logic [NUM_FU-1:0][RS_IDX_W-1:0]   clear_idx
);

  logic flush;
  assign flush = reset | mispredict;

  logic [RS_SZ-1:0]            ready;
  logic [RS_SZ-1:0][AGE_W-1:0] age;

  // Age is distance from the ROB head modulo ROB_SZ; the subtraction wraps
  // naturally in AGE_W bits. In index mode every age is equal, so the
  // picker's tie-break alone ranks by RS index.
  always_comb begin
    ready = '0;
    age   = '0;
    for (int unsigned i = 0; i < RS_SZ; i++) begin
      ready[i] = rs_ready(rs_entries[i]);
      if (POLICY == OLDEST) begin
        age[i] = AGE_W'(rs_entries[i].rob_idx) - rob_head;
      end
    end
  end

  // Cascade of pickers: stage k ranks k-th, having removed the winners of
  // all earlier stages from its candidate set.
  logic [RS_SZ-1:0]                 avail [NUM_FU+1];
  logic [RS_SZ-1:0]                 stage_grant [NUM_FU];
  logic [NUM_FU-1:0]                stage_found;
  logic [NUM_FU-1:0][RS_IDX_W-1:0]  stage_idx;

  assign avail[0] = ready;

  for (genvar k = 0; k < NUM_FU; k++) begin : g_stage
    oldest_picker #(
      .RS_SZ (RS_SZ),
      .AGE_W (AGE_W),
      .IDX_W (RS_IDX_W)
    ) u_pick (
      .req       (avail[k]),
      .age       (age),
      .grant     (stage_grant[k]),
      .grant_idx (stage_idx[k]),
      .found     (stage_found[k])
    );
    assign avail[k+1] = avail[k] & ~stage_grant[k];
  end

  logic                             slot_valid [NUM_FU];
  RS_ENTRY                          slot_entry [NUM_FU];
  logic [NUM_FU-1:0]                accept;
  logic [NUM_FU-1:0]                alloc;
  logic [NUM_FU-1:0][RS_IDX_W-1:0]  alloc_idx;

  // Stalled slots are skipped when counting, so the k-th ranked entry lands
  // on the k-th accepting slot in ascending slot order.
  always_comb begin
    int unsigned rank;
    accept    = '0;
    alloc     = '0;
    alloc_idx = '0;
    rank      = 0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      accept[f] = ~slot_valid[f] | fu_ready[f];
      if (accept[f]) begin
        for (int unsigned k = 0; k < NUM_FU; k++) begin
          if ((k == rank) && stage_found[k]) begin
            alloc[f]     = 1'b1;
            alloc_idx[f] = stage_idx[k];
          end
        end
        rank = rank + 1;
      end
    end
  end

  // The RS bank is flushed independently, so no clear is sent during a flush.
  always_comb begin
    clear_valid = '0;
    clear_idx   = '0;
    if (!flush) begin
      clear_valid = alloc;
      clear_idx   = alloc_idx;
    end
  end

  for (genvar f = 0; f < NUM_FU; f++) begin : g_slot
    always_ff @(posedge clock) begin
      if (flush) begin
        slot_valid[f] <= 1'b0;
        slot_entry[f] <= '0;
      end else if (accept[f]) begin
        slot_valid[f] <= alloc[f];
        if (alloc[f]) begin
          slot_entry[f] <= rs_entries[alloc_idx[f]];
        end
      end
    end
  end

  always_comb begin
    issue_valid = '0;
    issue_entry = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      issue_valid[f] = slot_valid[f];
      issue_entry[f] = slot_entry[f];
    end
  end

endmodule

// File: tb/tb_issue_select_unit.sv
module tb_issue_select_unit;
  import issue_select_unit_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic mispredict;
  logic [4:0] rob_head;

  always #5 clock = ~clock;

  // A: oldest-first, 8 entries, 2 FUs
  RS_ENTRY [7:0]       rs_a;
  logic [1:0]          fu_a, iv_a, cv_a;
  RS_ENTRY [1:0]       ie_a;
  logic [1:0][2:0]     ci_a;
  // B: index policy
  RS_ENTRY [7:0]       rs_b;
  logic [1:0]          fu_b, iv_b, cv_b;
  RS_ENTRY [1:0]       ie_b;
  logic [1:0][2:0]     ci_b;
  // C: 16 entries, 3 FUs
  RS_ENTRY [15:0]      rs_c;
  logic [2:0]          fu_c, iv_c, cv_c;
  RS_ENTRY [2:0]       ie_c;
  logic [2:0][3:0]     ci_c;

  issue_select_unit #(.RS_SZ(8), .NUM_FU(2), .ROB_SZ(32), .POLICY(OLDEST)) dut_a (
    .clock(clock), .reset(reset), .mispredict(mispredict), .rs_entries(rs_a),
    .rob_head(rob_head), .fu_ready(fu_a), .issue_valid(iv_a), .issue_entry(ie_a),
    .clear_valid(cv_a), .clear_idx(ci_a));

  issue_select_unit #(.RS_SZ(8), .NUM_FU(2), .ROB_SZ(32), .POLICY(INDEX)) dut_b (
    .clock(clock), .reset(reset), .mispredict(mispredict), .rs_entries(rs_b),
    .rob_head(rob_head), .fu_ready(fu_b), .issue_valid(iv_b), .issue_entry(ie_b),
    .clear_valid(cv_b), .clear_idx(ci_b));

  issue_select_unit #(.RS_SZ(16), .NUM_FU(3), .ROB_SZ(32), .POLICY(OLDEST)) dut_c (
    .clock(clock), .reset(reset), .mispredict(mispredict), .rs_entries(rs_c),
    .rob_head(rob_head), .fu_ready(fu_c), .issue_valid(iv_c), .issue_entry(ie_c),
    .clear_valid(cv_c), .clear_idx(ci_c));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic RS_ENTRY mk(input logic [4:0] rob);
    RS_ENTRY e;
    e            = '0;
    e.valid      = 1'b1;
    e.src1_ready = 1'b1;
    e.src2_ready = 1'b1;
    e.rob_idx    = rob;
    e.opcode     = rob[3:0] ^ 4'h5;
    e.dest_tag   = rob + 5'd1;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RS_ENTRY nr;
    int n, rem, xfer, last_age, age;
    int unsigned idx, rob;
    logic [15:0] used_pos, rm;
    logic [31:0] used_rob, seen;

    reset = 1'b1; mispredict = 1'b0; rob_head = '0;
    rs_a = '0; rs_b = '0; rs_c = '0;
    fu_a = 2'b11; fu_b = 2'b11; fu_c = 3'b111;
    tick; tick;

    // Reset values
    chk("rst_issue_valid", iv_a, 2'b00);
    chk("rst_issue_entry", ie_a, '0);
    chk("rst_clear_valid", cv_a, 2'b00);
    chk("rst_clear_idx", ci_a, '0);
    reset = 1'b0;

    // Idle: nothing ready
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_issue_valid", iv_a, 2'b00);
      chk("idle_clear_valid", cv_a, 2'b00);
      tick;
    end

    // Index policy picks RS2, RS5 although RS7 (age 0) and RS5 (age 1) are oldest
    rob_head = 5'd30;
    rs_b[2] = mk(5'd9); rs_b[5] = mk(5'd31); rs_b[7] = mk(5'd30);
    #1;
    chk("idx_clear_valid", cv_b, 2'b11);
    chk("idx_clear_idx0", ci_b[0], 3'd2);
    chk("idx_clear_idx1", ci_b[1], 3'd5);
    tick;
    rs_b[2] = '0; rs_b[5] = '0;
    #1;
    chk("idx_issue_valid", iv_b, 2'b11);
    chk("idx_entry0", ie_b[0], mk(5'd9));
    chk("idx_entry1", ie_b[1], mk(5'd31));
    chk("idx_clear_next", cv_b, 2'b01);
    chk("idx_clear_next_idx", ci_b[0], 3'd7);
    tick;
    rs_b[7] = '0;

    // Age order with head wrap: ages RS0=7, RS3=1, RS6=3; RS7 not ready
    nr = mk(5'd30); nr.src2_ready = 1'b0;
    rs_a[0] = mk(5'd5); rs_a[3] = mk(5'd31); rs_a[6] = mk(5'd1); rs_a[7] = nr;
    #1;
    chk("age_clear_valid", cv_a, 2'b11);
    chk("age_clear_idx0", ci_a[0], 3'd3);
    chk("age_clear_idx1", ci_a[1], 3'd6);
    tick;
    rs_a[3] = '0; rs_a[6] = '0;
    #1;
    chk("age_issue_valid", iv_a, 2'b11);
    chk("age_entry0_rob", ie_a[0].rob_idx, 5'd31);
    chk("age_entry1_rob", ie_a[1].rob_idx, 5'd1);
    chk("age_next_clear", cv_a, 2'b01);
    chk("age_next_idx", ci_a[0], 3'd0);
    tick;
    rs_a[0] = '0; rs_a[7] = '0;
    #1;
    chk("age_last_valid", iv_a, 2'b01);
    chk("age_last_entry", ie_a[0], mk(5'd5));
    chk("age_notready_clear", cv_a, 2'b00);
    tick;
    #1;
    chk("age_drain", iv_a, 2'b00);

    // Stall: slot0 holds rob 10 for 3 cycles while slot1 keeps taking work
    rs_a[1] = mk(5'd10);
    #1;
    chk("stall_load_clear", cv_a, 2'b01);
    chk("stall_load_idx", ci_a[0], 3'd1);
    tick;
    rs_a[1] = '0; rs_a[2] = mk(5'd20); rs_a[4] = mk(5'd0); fu_a = 2'b10;
    #1;
    chk("stall1_valid", iv_a, 2'b01);
    chk("stall1_entry0", ie_a[0], mk(5'd10));
    chk("stall1_clear", cv_a, 2'b10);
    chk("stall1_idx1", ci_a[1], 3'd4);
    tick;
    rs_a[4] = '0;
    #1;
    chk("stall2_valid", iv_a, 2'b11);
    chk("stall2_entry0", ie_a[0], mk(5'd10));
    chk("stall2_entry1", ie_a[1], mk(5'd0));
    chk("stall2_clear", cv_a, 2'b10);
    chk("stall2_idx1", ci_a[1], 3'd2);
    tick;
    rs_a[2] = '0;
    #1;
    chk("stall3_valid", iv_a, 2'b11);
    chk("stall3_entry0", ie_a[0], mk(5'd10));
    chk("stall3_entry1", ie_a[1], mk(5'd20));
    chk("stall3_clear", cv_a, 2'b00);
    tick;
    fu_a = 2'b11;
    #1;
    chk("stall_end_valid", iv_a, 2'b01);
    chk("stall_end_entry0", ie_a[0], mk(5'd10));
    tick;
    #1;
    chk("stall_drain", iv_a, 2'b00);

    // All slots stalled, then mispredict while slot1 stalls
    rs_a[5] = mk(5'd2); rs_a[7] = mk(5'd3);
    #1;
    chk("mp_load_clear", cv_a, 2'b11);
    chk("mp_load_idx0", ci_a[0], 3'd5);
    chk("mp_load_idx1", ci_a[1], 3'd7);
    tick;
    rs_a[5] = '0; rs_a[7] = '0; rs_a[0] = mk(5'd4); fu_a = 2'b00;
    #1;
    chk("allstall_valid", iv_a, 2'b11);
    chk("allstall_clear", cv_a, 2'b00);
    tick;
    fu_a = 2'b01; mispredict = 1'b1;
    #1;
    chk("mp_entry0", ie_a[0], mk(5'd2));
    chk("mp_entry1", ie_a[1], mk(5'd3));
    chk("mp_clear", cv_a, 2'b00);
    tick;
    mispredict = 1'b0; fu_a = 2'b11;
    #1;
    chk("mp_after_valid", iv_a, 2'b00);
    chk("mp_after_entry", ie_a, '0);
    chk("mp_resume_clear", cv_a, 2'b01);
    chk("mp_resume_idx", ci_a[0], 3'd0);
    tick;
    rs_a[0] = '0;
    #1;
    chk("mp_resume_valid", iv_a, 2'b01);
    chk("mp_resume_entry", ie_a[0], mk(5'd4));

    // Random stress on the 3-FU, 16-entry instance
    for (int w = 0; w < 6; w++) begin
      rob_head = 5'($urandom_range(0, 31));
      n = int'($urandom_range(3, 16));
      used_pos = '0; used_rob = '0; seen = '0;
      for (int e = 0; e < n; e++) begin
        do idx = $urandom_range(0, 15); while (used_pos[idx]);
        used_pos[idx] = 1'b1;
        do rob = $urandom_range(0, 31); while (used_rob[rob]);
        used_rob[rob] = 1'b1;
        rs_c[idx] = mk(5'(rob));
      end
      rem = 0; xfer = 0; last_age = -1;
      for (int cyc = 0; cyc < 400; cyc++) begin
        if (rem == n && iv_c == 3'b000) break;
        fu_c = 3'($urandom);
        #1;
        rm = '0;
        for (int f = 0; f < 3; f++) begin
          if (iv_c[f] && fu_c[f]) begin
            chk("stress_dup", seen[ie_c[f].rob_idx], 1'b0);
            seen[ie_c[f].rob_idx] = 1'b1;
            xfer++;
          end
          if (cv_c[f]) begin
            chk("stress_live", rs_c[ci_c[f]].valid & ~rm[ci_c[f]], 1'b1);
            age = (int'(rs_c[ci_c[f]].rob_idx) - int'(rob_head) + 32) % 32;
            chk("stress_order", age >= last_age, 1'b1);
            last_age = age;
            rm[ci_c[f]] = 1'b1;
            rem++;
          end
        end
        tick;
        for (int i = 0; i < 16; i++) if (rm[i]) rs_c[i] = '0;
      end
      chk("stress_drained", (rem == n) && (iv_c == 3'b000), 1'b1);
      chk("stress_xfer_count", xfer, n);
      chk("stress_all_issued", seen, used_rob);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
